// File: rtl/branch_pkg.sv
// Shared branch constants for the execute-stage branch resolver and the
// control-unit branch decoder.
//   BU_*      : 3-bit bu_op encodings
//   FLG_*     : bit positions of {V,C,N,Z} in alu_flags / flag_we / ccr
//   bu_state_e: flush FSM states
//   cond_met  : evaluates a conditional jump against a CCR value
package branch_pkg;

  localparam logic [2:0] BU_NONE = 3'b000;
  localparam logic [2:0] BU_JZ   = 3'b001;
  localparam logic [2:0] BU_JN   = 3'b010;
  localparam logic [2:0] BU_JC   = 3'b011;
  localparam logic [2:0] BU_JV   = 3'b100;
  localparam logic [2:0] BU_LOOP = 3'b101;

  localparam int unsigned FLG_Z     = 0;
  localparam int unsigned FLG_N     = 1;
  localparam int unsigned FLG_C     = 2;
  localparam int unsigned FLG_V     = 3;
  localparam int unsigned NUM_FLAGS = 4;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StFlush = 1'b1
  } bu_state_e;

  // True when op is a conditional jump whose flag is set; false for everything else.
  function automatic logic cond_met(input logic [2:0] op, input logic [NUM_FLAGS-1:0] ccr);
    logic res;
    res = 1'b0;
    case (op)
      BU_JZ:   res = ccr[FLG_Z];
      BU_JN:   res = ccr[FLG_N];
      BU_JC:   res = ccr[FLG_C];
      BU_JV:   res = ccr[FLG_V];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_jcc(input logic [2:0] op);
    return (op == BU_JZ) || (op == BU_JN) || (op == BU_JC) || (op == BU_JV);
  endfunction

endpackage

// File: rtl/ccr_reg.sv
// Condition-code register: four flags {V,C,N,Z}, each written from alu_flags when its
// flag_we bit is set on a non-stalled edge, otherwise held.
//   clk, rst   : clock, synchronous active-high reset (clears all flags)
//   stall      : hold all flags this cycle
//   alu_flags  : new flag values {V,C,N,Z}
//   flag_we    : per-flag write enable, same bit order
//   ccr        : current flags
module ccr_reg
  import branch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NUM_FLAGS-1:0] alu_flags,
  input  logic [NUM_FLAGS-1:0] flag_we,
  output logic [NUM_FLAGS-1:0] ccr
);

  logic [NUM_FLAGS-1:0] ccr_q, ccr_d;

  always_comb begin
    ccr_d = ccr_q;
    if (!stall) begin
      ccr_d = (ccr_q & ~flag_we) | (alu_flags & flag_we);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q <= '0;
    end else begin
      ccr_q <= ccr_d;
    end
  end

  assign ccr = ccr_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver. Evaluates JZ/JN/JC/JV against the CCR value held before
// the current edge, executes LOOP (decrement Ra, branch while non-zero), and runs a flush
// sequence that squashes IF/ID for FLUSH_CYCLES cycles after every taken branch. Ops that
// arrive during the flush are wrong-path and are ignored (their flag writes still land).
//   clk, rst      : clock, synchronous active-high reset
//   stall         : freeze FSM, counter, CCR and all outputs
//   valid_in      : EX instruction valid
//   bu_op         : branch op from the decoder (see branch_pkg)
//   ra_val        : LOOP counter operand
//   rb_val        : branch target
//   alu_flags     : {V,C,N,Z} from the ALU
//   flag_we       : per-flag write enable
//   taken         : one-cycle redirect pulse
//   target_pc     : redirect address
//   loop_wb_en    : one-cycle Ra writeback pulse
//   loop_wb_data  : ra_val - 1
//   flush_if_id   : squash IF/ID
//   busy          : flush in progress
//   ccr           : current {V,C,N,Z}
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 valid_in,
  input  logic [2:0]           bu_op,
  input  logic [DATA_W-1:0]    ra_val,
  input  logic [DATA_W-1:0]    rb_val,
  input  logic [NUM_FLAGS-1:0] alu_flags,
  input  logic [NUM_FLAGS-1:0] flag_we,
  output logic                 taken,
  output logic [DATA_W-1:0]    target_pc,
  output logic                 loop_wb_en,
  output logic [DATA_W-1:0]    loop_wb_data,
  output logic                 flush_if_id,
  output logic                 busy,
  output logic [NUM_FLAGS-1:0] ccr
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  bu_state_e          state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               taken_q, taken_d;
  logic [DATA_W-1:0]  target_q, target_d;
  logic               wb_en_q, wb_en_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic [NUM_FLAGS-1:0] ccr_cur;
  logic               accept;
  logic [DATA_W-1:0]  loop_dec;

  // CCR output is the pre-edge value, which is exactly what conditions must see.
  ccr_reg u_ccr_reg (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .alu_flags (alu_flags),
    .flag_we   (flag_we),
    .ccr       (ccr_cur)
  );

  assign loop_dec = ra_val - DATA_W'(1);
  assign accept   = valid_in && !stall && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    taken_d   = taken_q;
    target_d  = target_q;
    wb_en_d   = wb_en_q;
    wb_data_d = wb_data_q;

    if (!stall) begin
      // Pulses last one non-stalled cycle.
      taken_d = 1'b0;
      wb_en_d = 1'b0;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_jcc(bu_op)) begin
              taken_d  = cond_met(bu_op, ccr_cur);
              target_d = rb_val;
            end else if (bu_op == BU_LOOP) begin
              wb_en_d   = 1'b1;
              wb_data_d = loop_dec;
              taken_d   = (loop_dec != '0);
              target_d  = rb_val;
            end
          end
          if (taken_d) begin
            state_d = StFlush;
            cnt_d   = FlushLoad;
          end
        end
        StFlush: begin
          if (cnt_q == 3'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign taken        = taken_q;
  assign target_pc    = target_q;
  assign loop_wb_en   = wb_en_q;
  assign loop_wb_data = wb_data_q;
  assign flush_if_id  = (state_q == StFlush);
  assign busy         = (state_q == StFlush);
  assign ccr          = ccr_cur;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with DATA_W=8, FLUSH_CYCLES=2.
module tb_branch_resolve_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       valid_in;
  logic [2:0] bu_op;
  logic [7:0] ra_val;
  logic [7:0] rb_val;
  logic [3:0] alu_flags;
  logic [3:0] flag_we;
  logic       taken;
  logic [7:0] target_pc;
  logic       loop_wb_en;
  logic [7:0] loop_wb_data;
  logic       flush_if_id;
  logic       busy;
  logic [3:0] ccr;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] OpNone = 3'b000;
  localparam logic [2:0] OpJz   = 3'b001;
  localparam logic [2:0] OpJn   = 3'b010;
  localparam logic [2:0] OpJc   = 3'b011;
  localparam logic [2:0] OpJv   = 3'b100;
  localparam logic [2:0] OpLoop = 3'b101;

  branch_resolve_unit #(
    .DATA_W       (8),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .valid_in     (valid_in),
    .bu_op        (bu_op),
    .ra_val       (ra_val),
    .rb_val       (rb_val),
    .alu_flags    (alu_flags),
    .flag_we      (flag_we),
    .taken        (taken),
    .target_pc    (target_pc),
    .loop_wb_en   (loop_wb_en),
    .loop_wb_data (loop_wb_data),
    .flush_if_id  (flush_if_id),
    .busy         (busy),
    .ccr          (ccr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] ra,
                       input logic [7:0] rb, input logic [3:0] flg, input logic [3:0] we);
    valid_in  = v;
    bu_op     = op;
    ra_val    = ra;
    rb_val    = rb;
    alu_flags = flg;
    flag_we   = we;
  endtask

  task automatic idle_in();
    drive(1'b0, OpNone, 8'h00, 8'h00, 4'h0, 4'h0);
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
    check("rst_taken", taken, 0);
    check("rst_target", target_pc, 0);
    check("rst_wb_en", loop_wb_en, 0);
    check("rst_wb_data", loop_wb_data, 0);
    check("rst_flush", flush_if_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ccr", ccr, 0);

    // 1: set Z, taken JZ, two-cycle flush
    drive(1'b0, OpNone, 8'h00, 8'h00, 4'b0001, 4'b0001);
    tick();
    check("t1_ccr", ccr, 4'b0001);
    drive(1'b1, OpJz, 8'h00, 8'h40, 4'h0, 4'h0);
    tick();
    check("t1_taken", taken, 1);
    check("t1_target", target_pc, 8'h40);
    check("t1_flush0", flush_if_id, 1);
    check("t1_busy0", busy, 1);
    idle_in();
    tick();
    check("t1_taken_drop", taken, 0);
    check("t1_flush1", flush_if_id, 1);
    tick();
    check("t1_flush2", flush_if_id, 0);
    check("t1_busy2", busy, 0);

    // 2: LOOP taken, not taken, wrap
    drive(1'b1, OpLoop, 8'h03, 8'h10, 4'h0, 4'h0);
    tick();
    check("t2a_wb_en", loop_wb_en, 1);
    check("t2a_wb_data", loop_wb_data, 8'h02);
    check("t2a_taken", taken, 1);
    check("t2a_target", target_pc, 8'h10);
    idle_in();
    tick();
    check("t2a_wb_drop", loop_wb_en, 0);
    tick();
    drive(1'b1, OpLoop, 8'h01, 8'h20, 4'h0, 4'h0);
    tick();
    check("t2b_wb_en", loop_wb_en, 1);
    check("t2b_wb_data", loop_wb_data, 8'h00);
    check("t2b_taken", taken, 0);
    check("t2b_flush", flush_if_id, 0);
    drive(1'b1, OpLoop, 8'h00, 8'h30, 4'h0, 4'h0);
    tick();
    check("t2c_wb_data", loop_wb_data, 8'hFF);
    check("t2c_taken", taken, 1);
    check("t2c_target", target_pc, 8'h30);
    idle_in();
    tick();
    tick();
    check("t2c_idle", busy, 0);

    // 3: same-cycle flag write does not affect the branch
    drive(1'b1, OpJn, 8'h00, 8'h50, 4'b0010, 4'b0010);
    tick();
    check("t3_old_ccr", taken, 0);
    check("t3_ccr", ccr, 4'b0011);
    drive(1'b1, OpJn, 8'h00, 8'h50, 4'h0, 4'h0);
    tick();
    check("t3_new_ccr", taken, 1);
    idle_in();
    tick();
    tick();

    // 4: ops in the flush window are squashed, flag writes still land
    drive(1'b0, OpNone, 8'h00, 8'h00, 4'b1100, 4'b1100);
    tick();
    check("t4_ccr_set", ccr, 4'b1111);
    drive(1'b1, OpJc, 8'h00, 8'h55, 4'h0, 4'h0);
    tick();
    check("t4_jc_taken", taken, 1);
    drive(1'b1, OpJv, 8'h00, 8'h66, 4'h0, 4'h0);
    tick();
    check("t4_jv_squash", taken, 0);
    check("t4_jv_target", target_pc, 8'h55);
    check("t4_flush", flush_if_id, 1);
    drive(1'b1, OpLoop, 8'h05, 8'h77, 4'b0000, 4'b0001);
    tick();
    check("t4_loop_taken", taken, 0);
    check("t4_loop_wb", loop_wb_en, 0);
    check("t4_loop_data", loop_wb_data, 8'hFF);
    check("t4_idle", busy, 0);
    check("t4_ccr_sq", ccr, 4'b1110);

    // 5: stall while taken during flush
    drive(1'b1, OpJc, 8'h00, 8'h88, 4'h0, 4'h0);
    tick();
    check("t5_taken", taken, 1);
    stall = 1'b1;
    drive(1'b1, OpJn, 8'h09, 8'h99, 4'b0000, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_taken", taken, 1);
      check("t5_hold_flush", flush_if_id, 1);
      check("t5_hold_target", target_pc, 8'h88);
    end
    check("t5_hold_ccr", ccr, 4'b1110);
    check("t5_hold_wb", loop_wb_en, 0);
    stall = 1'b0;
    idle_in();
    tick();
    check("t5_rel_taken", taken, 0);
    check("t5_rel_flush", flush_if_id, 1);
    tick();
    check("t5_done", flush_if_id, 0);

    // 6: reset mid-flush, then immediate acceptance
    drive(1'b1, OpJn, 8'h00, 8'h99, 4'h0, 4'h0);
    tick();
    check("t6_taken", taken, 1);
    rst = 1'b1;
    drive(1'b0, OpNone, 8'h00, 8'h00, 4'b1111, 4'b1111);
    tick();
    rst = 1'b0;
    check("t6_taken0", taken, 0);
    check("t6_target0", target_pc, 0);
    check("t6_flush0", flush_if_id, 0);
    check("t6_busy0", busy, 0);
    check("t6_ccr0", ccr, 0);
    drive(1'b1, OpJz, 8'h00, 8'hAB, 4'b0001, 4'b0001);
    tick();
    check("t6_jz_taken", taken, 0);
    check("t6_jz_target", target_pc, 8'hAB);
    check("t6_ccr_z", ccr, 4'b0001);

    // valid_in=0 and reserved ops are no-ops even with Z set
    drive(1'b0, OpJz, 8'h02, 8'hC0, 4'h0, 4'h0);
    tick();
    check("bubble_taken", taken, 0);
    check("bubble_target", target_pc, 8'hAB);
    drive(1'b1, 3'b111, 8'h02, 8'hC1, 4'h0, 4'h0);
    tick();
    check("rsvd_taken", taken, 0);
    check("rsvd_wb", loop_wb_en, 0);
    check("rsvd_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
